// File: rtl/dac_serial_monitor.sv
// rtl/dac_serial_monitor.sv - oversampling deframer and shadow register file for the DAC serial write interface
module dac_serial_monitor #(
  parameter int         FRAME_BITS  = 24,
  parameter int         N_CH        = 8,
  parameter logic [3:0] CMD_WRITE   = 4'h3,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ser_clk,
  input  logic                  nsync,
  input  logic                  din,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [15:0]           frame_count,
  output logic [16*N_CH-1:0]    shadow,
  output logic                  busy
);

  localparam int             CW       = $clog2(2*FRAME_BITS + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(2*FRAME_BITS);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Index SYNC_STAGES-1 is the synchronizer output, index SYNC_STAGES the history flop.
  logic [SYNC_STAGES:0] clk_pipe;
  logic [SYNC_STAGES:0] ns_pipe;
  logic [SYNC_STAGES:0] din_pipe;

  logic [FRAME_BITS-1:0] shreg;
  logic [CW-1:0]         bit_cnt;

  logic sclk_fall, ns_fall, ns_rise, ns_low, din_s;
  logic start, shift_en, eval;

  logic [3:0]  f_cmd;
  logic [3:0]  f_addr;
  logic [15:0] f_data;

  // Synchronize all three lines through identical pipelines. nsync resets low so that
  // a frame already in progress when reset is released never produces a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_pipe <= '0;
      ns_pipe  <= '0;
      din_pipe <= '0;
    end else begin
      clk_pipe <= {clk_pipe[SYNC_STAGES-1:0], ser_clk};
      ns_pipe  <= {ns_pipe[SYNC_STAGES-1:0], nsync};
      din_pipe <= {din_pipe[SYNC_STAGES-1:0], din};
    end
  end

  assign sclk_fall = clk_pipe[SYNC_STAGES] & ~clk_pipe[SYNC_STAGES-1];
  assign ns_fall   = ns_pipe[SYNC_STAGES] & ~ns_pipe[SYNC_STAGES-1];
  assign ns_rise   = ~ns_pipe[SYNC_STAGES] & ns_pipe[SYNC_STAGES-1];
  assign ns_low    = ~ns_pipe[SYNC_STAGES-1];
  // din from the history stage is the value held while ser_clk was still high.
  assign din_s     = din_pipe[SYNC_STAGES];

  assign f_cmd  = shreg[FRAME_BITS-1 -: 4];
  assign f_addr = shreg[FRAME_BITS-5 -: 4];
  assign f_data = shreg[15:0];

  assign busy = (state == SHIFT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and datapath strobes; an nsync rise wins over a coincident ser_clk fall.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    eval      = 1'b0;
    case (state)
      IDLE: begin
        if (ns_fall) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ns_rise) begin
          state_nxt = DONE;
        end else if (sclk_fall && ns_low) begin
          shift_en = 1'b1;
        end
      end
      DONE: begin
        eval = 1'b1;
        if (ns_fall) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and saturating bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (start) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[FRAME_BITS-2:0], din_s};
      if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Frame evaluation: publish good frames, update shadow on in-range writes, flag bad lengths.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      shadow      <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (eval) begin
        if (bit_cnt == CNT_FULL) begin
          frame_data  <= shreg;
          frame_valid <= 1'b1;
          frame_count <= frame_count + 16'd1;
          if (f_cmd == CMD_WRITE) begin
            for (int c = 0; c < N_CH; c++) begin
              if (int'(f_addr) == c) shadow[16*c +: 16] <= f_data;
            end
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule
